// File: rtl/serial_parity_checker.sv
// rtl/serial_parity_checker.sv - serial frame receiver with even/odd parity check
module serial_parity_checker #(
    parameter int DATA_W = 8,
    parameter bit ODD    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              par_out,
    output logic              par_err,
    output logic              par_valid
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY
    } state_t;

    state_t              state_q, state_d;
    logic                acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   sh_q, sh_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                par_q, par_d;
    logic                err_q, err_d;
    logic                pv_q, pv_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            err_q   <= 1'b0;
            pv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            par_q   <= par_d;
            err_q   <= err_d;
            pv_q    <= pv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        data_d  = data_q;
        par_d   = par_q;
        err_d   = err_q;
        pv_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DATA;
                    acc_d   = ODD;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_valid) begin
                    acc_d = acc_q ^ bit_in;
                    sh_d  = {bit_in, sh_q[DATA_W-1:1]};
                    // Counter parks on the last index instead of wrapping.
                    if (cnt_q == LAST) begin
                        state_d = S_PARITY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_valid) begin
                    par_d   = acc_q;
                    err_d   = bit_in ^ acc_q;
                    data_d  = sh_q;
                    pv_d    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q == S_DATA) || (state_q == S_PARITY);
    assign data_out  = data_q;
    assign par_out   = par_q;
    assign par_err   = err_q;
    assign par_valid = pv_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// tb/tb_serial_parity_checker.sv - directed and random frames against a parity reference model
module tb_serial_parity_checker;

    logic       clk;
    logic       rst;
    logic       start;
    logic       bit_in;
    logic       bit_valid;
    logic       busy_e, busy_o;
    logic [7:0] data_e, data_o;
    logic       par_e, par_o;
    logic       err_e, err_o;
    logic       pv_e, pv_o;

    int checks;
    int errors;
    int cyc;

    logic [7:0] m_data;
    logic       m_par_e, m_par_o, m_err_e, m_err_o;

    serial_parity_checker #(.DATA_W(8), .ODD(1'b0)) u_even (
        .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .busy(busy_e), .data_out(data_e), .par_out(par_e), .par_err(err_e), .par_valid(pv_e)
    );

    serial_parity_checker #(.DATA_W(8), .ODD(1'b1)) u_odd (
        .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .busy(busy_o), .data_out(data_o), .par_out(par_o), .par_err(err_o), .par_valid(pv_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic exp_pv, input logic exp_busy);
        chk({tag, ".pv_even"},   32'(pv_e),   32'(exp_pv));
        chk({tag, ".pv_odd"},    32'(pv_o),   32'(exp_pv));
        chk({tag, ".busy_even"}, 32'(busy_e), 32'(exp_busy));
        chk({tag, ".busy_odd"},  32'(busy_o), 32'(exp_busy));
        chk({tag, ".data_even"}, 32'(data_e), 32'(m_data));
        chk({tag, ".data_odd"},  32'(data_o), 32'(m_data));
        chk({tag, ".par_even"},  32'(par_e),  32'(m_par_e));
        chk({tag, ".par_odd"},   32'(par_o),  32'(m_par_o));
        chk({tag, ".err_even"},  32'(err_e),  32'(m_err_e));
        chk({tag, ".err_odd"},   32'(err_o),  32'(m_err_o));
    endtask

    task automatic model_clear();
        m_data  = 8'h00;
        m_par_e = 1'b0;
        m_par_o = 1'b0;
        m_err_e = 1'b0;
        m_err_o = 1'b0;
    endtask

    // Even parity is the count of ones mod 2; odd parity is its complement.
    task automatic model_frame(input logic [7:0] d, input logic pbit);
        m_data  = d;
        m_par_e = ($countones(d) % 2) == 1;
        m_par_o = !m_par_e;
        m_err_e = pbit != m_par_e;
        m_err_o = pbit != m_par_o;
    endtask

    task automatic frame(input string tag, input logic [7:0] d, input logic pbit,
                         input int gmin, input int gmax, input bit noise, input bit hold,
                         output int pv_cyc);
        int g;
        start     = 1'b1;
        bit_valid = 1'($urandom);
        bit_in    = 1'($urandom);
        @(negedge clk);
        chk_all({tag, ".start"}, 1'b0, 1'b1);
        for (int i = 0; i <= 8; i++) begin
            g = $urandom_range(gmax, gmin);
            repeat (g) begin
                bit_valid = 1'b0;
                bit_in    = 1'($urandom);
                start     = noise ? 1'($urandom) : hold;
                @(negedge clk);
                chk_all({tag, ".gap"}, 1'b0, 1'b1);
            end
            bit_valid = 1'b1;
            bit_in    = (i < 8) ? d[i] : pbit;
            start     = noise ? 1'($urandom) : hold;
            @(negedge clk);
            if (i < 8) chk_all({tag, ".bit"}, 1'b0, 1'b1);
        end
        bit_valid = 1'b0;
        start     = hold;
        model_frame(d, pbit);
        chk_all({tag, ".done"}, 1'b1, 1'b0);
        pv_cyc = cyc;
    endtask

    task automatic idle_hold(input string tag, input int n);
        repeat (n) begin
            start     = 1'b0;
            bit_valid = 1'($urandom);
            bit_in    = 1'($urandom);
            @(negedge clk);
            chk_all(tag, 1'b0, 1'b0);
        end
    endtask

    int c1, c2;
    logic [7:0] rd;

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        chk_all("reset", 1'b0, 1'b0);
        rst = 1'b0;
        idle_hold("post_reset_idle", 2);

        frame("a5_p0", 8'hA5, 1'b0, 0, 0, 1'b0, 1'b0, c1);
        frame("a5_p1", 8'hA5, 1'b1, 0, 0, 1'b0, 1'b0, c1);
        idle_hold("a5_hold", 5);

        frame("x01_p1", 8'h01, 1'b1, 0, 0, 1'b0, 1'b0, c1);
        frame("x01_p0", 8'h01, 1'b0, 0, 0, 1'b0, 1'b0, c1);
        idle_hold("x01_hold", 2);

        frame("ff_gaps", 8'hFF, 1'b0, 3, 3, 1'b1, 1'b0, c1);
        idle_hold("ff_after", 4);

        for (int k = 0; k < 6; k++) begin
            rd = 8'($urandom);
            frame("rand", rd, 1'($urandom), 0, 2, 1'($urandom), 1'b0, c1);
            idle_hold("rand_after", $urandom_range(2, 0));
        end

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'($urandom);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        model_clear();
        chk_all("async_reset", 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'($urandom);
            @(negedge clk);
            chk_all("needs_start", 1'b0, 1'b0);
        end
        bit_valid = 1'b0;
        frame("x3c", 8'h3C, 1'b0, 0, 0, 1'b0, 1'b0, c1);
        idle_hold("x3c_after", 2);

        frame("b2b_1", 8'h80, 1'b1, 0, 0, 1'b0, 1'b1, c1);
        frame("b2b_2", 8'h80, 1'b1, 0, 0, 1'b0, 1'b0, c2);
        chk("b2b_spacing", 32'(c2 - c1), 32'd10);
        idle_hold("b2b_after", 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_parity_checker.md
SERIAL_PARITY_CHECKER -- requirements
Module: serial_parity_checker

Interface
REQ-001 The block SHALL have a parameter DATA_W, default 8, giving the data bits per frame (legal range 2..32).
REQ-002 The block SHALL have a parameter ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  frame start request, sampled only in IDLE.
REQ-007 bit_in  input  1  serial data or parity bit, LSB first.
REQ-008 bit_valid  input  1  qualifies bit_in in the current cycle.
REQ-009 busy  output  1  high while in DATA or PARITY.
REQ-010 data_out  output  DATA_W  last completed frame data, LSB = first received bit.
REQ-011 par_out  output  1  computed parity of the last completed frame.
REQ-012 par_err  output  1  high when the received parity bit != par_out.
REQ-013 par_valid  output  1  one-cycle pulse marking a completed frame.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, DATA and PARITY.
REQ-015 In IDLE, start=1 SHALL move the FSM to DATA, load acc <= ODD and clear the bit counter; bit_valid SHALL be ignored in IDLE, including in the same cycle as start.
REQ-016 In DATA, each bit_valid=1 cycle SHALL do three things: acc <= acc ^ bit_in; shift bit_in into the shift register MSB with a right shift; increment the counter.
REQ-017 bit_valid=0 cycles SHALL hold all state; gaps of any length are legal.
REQ-018 On the DATA_W-th accepted data bit (counter == DATA_W-1 with bit_valid=1), the FSM SHALL move to PARITY.
REQ-019 In PARITY, the first bit_valid=1 cycle SHALL register four results: par_out <= acc; par_err <= bit_in ^ acc; data_out <= shift register; par_valid <= 1. The FSM SHALL then return to IDLE.
REQ-020 par_valid SHALL be high for exactly the one cycle following the edge that samples the parity bit, and low in every other cycle.
REQ-021 data_out, par_out and par_err SHALL hold their values until the next par_valid.
REQ-022 start SHALL be ignored in DATA and PARITY; a frame in progress is never restarted.
REQ-023 start=1 in the same cycle as par_valid=1 SHALL be accepted, because the FSM is already in IDLE; back-to-back frames therefore have no dead cycle.
REQ-024 busy SHALL be a decode of the state (DATA or PARITY) and SHALL carry no extra latency.
REQ-025 The counter SHALL be sized $clog2(DATA_W) and SHALL NOT wrap within a frame.
REQ-026 Minimum frame latency SHALL be DATA_W+2 cycles from the start edge to the par_valid cycle.

Reset
REQ-027 rst=1 SHALL immediately force the following, independent of clk: state=IDLE; acc, counter and shift register = 0; data_out=0; par_out=0; par_err=0; par_valid=0; busy=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame without producing par_valid.
REQ-029 After reset release, the first frame SHALL require a new start.

Verification
REQ-030 Scenario: DATA_W=8, ODD=0, start, then bits 1,0,1,0,0,1,0,1 (0xA5), then parity 0 -> par_valid one cycle, data_out=0xA5, par_out=0, par_err=0.
REQ-031 Scenario: same frame with parity bit 1 -> par_out=0, par_err=1; outputs hold through 5 idle cycles.
REQ-032 Scenario: ODD=1, data 0x01, parity 1 -> par_out=0, par_err=1; same frame with parity 0 -> par_err=0.
REQ-033 Scenario: 0xFF frame with 3-cycle bit_valid gaps between bits and start pulsed during DATA -> par_out=0, data_out=0xFF, exactly one par_valid.
REQ-034 Scenario: rst asserted between clock edges after 4 data bits -> outputs zero immediately, no par_valid; a following full 0x3C frame -> data_out=0x3C, par_out=0.
REQ-035 Scenario: start held high across two back-to-back 0x80 frames -> two par_valid pulses DATA_W+2 cycles apart, par_out=1 both times.
